// File: rtl/tune_pkg.sv
// Shared definitions for the tune sequencer.
// Holds the ROM note layout, the sequencer state encoding, the start
// addresses of the shipped tunes and the half-period values of the notes
// they use (clk = 50 MHz). The ROM image is built from these constants.
package tune_pkg;

  localparam int DEF_ADDR_W   = 32'sd8;
  localparam int DEF_PERIOD_W = 32'sd20;
  localparam int DEF_DUR_W    = 32'sd16;

  // One ROM word: {last, half_period, duration}
  typedef struct packed {
    logic                    last;
    logic [DEF_PERIOD_W-1:0] half_period;
    logic [DEF_DUR_W-1:0]    duration;
  } note_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    PLAY  = 3'd3,
    GAP   = 3'd4
  } state_e;

  // Tune start addresses inside the note ROM
  localparam logic [DEF_ADDR_W-1:0] TUNE_START_ADDR = 8'd0;
  localparam logic [DEF_ADDR_W-1:0] TUNE_COIN_ADDR  = 8'd8;
  localparam logic [DEF_ADDR_W-1:0] TUNE_OVER_ADDR  = 8'd16;

  // Half periods in clk cycles at 50 MHz; zero marks a rest
  localparam logic [DEF_PERIOD_W-1:0] HALF_REST = 20'd0;
  localparam logic [DEF_PERIOD_W-1:0] HALF_A4   = 20'd56818;
  localparam logic [DEF_PERIOD_W-1:0] HALF_C5   = 20'd47778;
  localparam logic [DEF_PERIOD_W-1:0] HALF_E5   = 20'd37921;
  localparam logic [DEF_PERIOD_W-1:0] HALF_G5   = 20'd31888;

  // Packs one ROM word
  function automatic note_t mk_note(input logic last,
                                    input logic [DEF_PERIOD_W-1:0] half,
                                    input logic [DEF_DUR_W-1:0] dur);
    note_t n;
    n.last        = last;
    n.half_period = half;
    n.duration    = dur;
    return n;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator for the buzzer.
// Ports: clk, rst_n (async, active low), restart (start a fresh phase,
// output high first), half_period (cycles per level; 0 = silent),
// out (registered square wave).
module tone_gen #(
  parameter int PERIOD_W = 32'sd20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                restart,
  input  logic [PERIOD_W-1:0] half_period,
  output logic                out
);

  // cnt_q is the 1-based position inside the current level
  logic [PERIOD_W-1:0] cnt_q;
  logic                out_q;

  // Phase counter and registered square-wave level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else if (half_period == '0) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else if (restart) begin
      cnt_q <= PERIOD_W'(1);
      out_q <= 1'b1;
    end else if (cnt_q >= half_period) begin
      cnt_q <= PERIOD_W'(1);
      out_q <= ~out_q;
    end else begin
      cnt_q <= cnt_q + PERIOD_W'(1);
    end
  end

  assign out = out_q;

endmodule

// File: rtl/tune_sequencer.sv
// Tune player: walks a note list in an external synchronous ROM and drives
// a square-wave buzzer, with rests, an articulation gap and prioritised
// requests.
// Ports: clk, rst_n (async, active low); req/req_addr/req_prio start
// request; req_ack accept pulse; rom_addr/rom_data note ROM interface
// (data one cycle after address); busy tune in progress; done pulse on
// natural completion; buzzer_out square wave.
module tune_sequencer
  import tune_pkg::*;
#(
  parameter int ADDR_W    = 32'sd8,
  parameter int PERIOD_W  = 32'sd20,
  parameter int DUR_W     = 32'sd16,
  parameter int TICK_DIV  = 32'sd50000,
  parameter int GAP_TICKS = 32'sd10,
  parameter int PRIO_W    = 32'sd2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [PRIO_W-1:0]         req_prio,
  output logic                      req_ack,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [PERIOD_W+DUR_W:0]   rom_data,
  output logic                      busy,
  output logic                      done,
  output logic                      buzzer_out
);

  localparam int PRESC_W = (TICK_DIV > 32'sd1) ? $clog2(TICK_DIV) : 32'sd1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 32'sd1);
  localparam bit GAP_EN = (GAP_TICKS > 32'sd0);
  localparam logic [DUR_W-1:0] GAP_LAST =
    DUR_W'(GAP_EN ? (GAP_TICKS - 32'sd1) : 32'sd0);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic [PRIO_W-1:0]   cur_prio_q;
  logic                busy_q, done_q, ack_q;
  logic                last_q;
  logic [PERIOD_W-1:0] half_q;
  logic [DUR_W-1:0]    dur_q;
  logic [PRESC_W-1:0]  presc_q;
  // Counts elapsed ticks; shared by PLAY (note length) and GAP
  logic [DUR_W-1:0]    tcnt_q;

  logic                tick_s, play_end_s, gap_end_s, note_end_s;
  logic                finish_s, accept_s, tone_restart_s, buzzer_s;
  logic [DUR_W-1:0]    dur_last_s;
  logic [PERIOD_W-1:0] tone_half_s;

  // Tick/end-of-note decode, request acceptance and next state
  always_comb begin
    tick_s     = (presc_q == PRESC_LAST);
    // A zero duration still plays for one tick
    dur_last_s = (dur_q == '0) ? '0 : (dur_q - DUR_W'(1));
    play_end_s = (state_q == PLAY) && tick_s && (tcnt_q == dur_last_s);
    gap_end_s  = (state_q == GAP) && tick_s && (tcnt_q == GAP_LAST);
    note_end_s = GAP_EN ? gap_end_s : play_end_s;
    finish_s   = note_end_s && last_q;
    // Natural completion beats a same-cycle request
    accept_s   = req && ((state_q == IDLE) ||
                         ((req_prio >= cur_prio_q) && !finish_s));
    state_d    = state_q;
    if (accept_s) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        IDLE:  state_d = IDLE;
        FETCH: state_d = LOAD;
        LOAD:  state_d = PLAY;
        PLAY: begin
          if (play_end_s) begin
            state_d = GAP_EN ? GAP : (last_q ? IDLE : FETCH);
          end else begin
            state_d = PLAY;
          end
        end
        GAP: begin
          if (gap_end_s) begin
            state_d = last_q ? IDLE : FETCH;
          end else begin
            state_d = GAP;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Tone only sounds while the next cycle is PLAY, so the registered
    // buzzer goes quiet on the very edge that leaves PLAY or accepts a req
    tone_restart_s = (state_q == LOAD);
    tone_half_s    = '0;
    if (state_d == PLAY) begin
      tone_half_s = (state_q == LOAD) ? rom_data[PERIOD_W+DUR_W-1:DUR_W] : half_q;
    end else begin
      tone_half_s = '0;
    end
  end

  // Sequencer state, note registers, prescaler and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      cur_prio_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      last_q     <= 1'b0;
      half_q     <= '0;
      dur_q      <= '0;
      presc_q    <= '0;
      tcnt_q     <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= accept_s;
      busy_q  <= (state_d != IDLE);
      done_q  <= 1'b0;
      if (accept_s) begin
        cur_prio_q <= req_prio;
        rom_addr_q <= req_addr;
      end else begin
        case (state_q)
          LOAD: begin
            last_q  <= rom_data[PERIOD_W+DUR_W];
            half_q  <= rom_data[PERIOD_W+DUR_W-1:DUR_W];
            dur_q   <= rom_data[DUR_W-1:0];
            presc_q <= '0;
            tcnt_q  <= '0;
          end
          PLAY, GAP: begin
            presc_q <= tick_s ? '0 : (presc_q + PRESC_W'(1));
            if (tick_s) begin
              tcnt_q <= tcnt_q + DUR_W'(1);
            end
            // The gap counts its own ticks from zero
            if (play_end_s) begin
              tcnt_q <= '0;
            end
            if (note_end_s) begin
              if (last_q) begin
                done_q     <= 1'b1;
                cur_prio_q <= '0;
              end else begin
                rom_addr_q <= rom_addr_q + ADDR_W'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  tone_gen #(
    .PERIOD_W(PERIOD_W)
  ) u_tone (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (tone_restart_s),
    .half_period(tone_half_s),
    .out        (buzzer_s)
  );

  assign req_ack    = ack_q;
  assign rom_addr   = rom_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign buzzer_out = buzzer_s;

endmodule

// File: tb/tb_tune_sequencer.sv
`timescale 1ns/1ps
module tb_tune_sequencer;
  import tune_pkg::*;

  localparam int AW = 8, PW = 20, DW = 16, TDIV = 4, GAPT = 1, PRW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req = 1'b0;
  logic [AW-1:0]     req_addr = '0;
  logic [PRW-1:0]    req_prio = '0;
  logic              req_ack, busy, done, buzzer_out;
  logic [AW-1:0]     rom_addr;
  logic [PW+DW:0]    rom_data;

  note_t rom [256];

  always #5 clk = ~clk;

  // Synchronous note ROM: data one cycle after address
  always @(posedge clk) rom_data <= rom[rom_addr];

  tune_sequencer #(
    .ADDR_W(AW), .PERIOD_W(PW), .DUR_W(DW),
    .TICK_DIV(TDIV), .GAP_TICKS(GAPT), .PRIO_W(PRW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
    .req_prio(req_prio), .req_ack(req_ack), .rom_addr(rom_addr),
    .rom_data(rom_data), .busy(busy), .done(done), .buzzer_out(buzzer_out)
  );

  // Expected per-cycle outputs; chk_a marks a fetch cycle whose rom_addr is known,
  // fin marks the last busy cycle of a tune
  typedef struct packed {
    logic       buz, bsy, dn, ack, chk_a, fin;
    logic [7:0] addr;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   model_prio = 0;
  bit   last_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expands a tune from the ROM image into its cycle-by-cycle waveform
  task automatic push_tune(input int a0);
    int a, half, dur, notes;
    bit first;
    note_t n;
    exp_t e;
    a = a0; first = 1; notes = 0;
    while (notes < 300) begin
      n = rom[a];
      q.push_back('{buz:1'b0, bsy:1'b1, dn:1'b0, ack:first, chk_a:1'b1, fin:1'b0, addr:a[7:0]});
      first = 0;
      q.push_back('{buz:1'b0, bsy:1'b1, dn:1'b0, ack:1'b0, chk_a:1'b0, fin:1'b0, addr:8'd0});
      half = int'(n.half_period);
      dur  = (n.duration == 16'd0) ? 1 : int'(n.duration);
      for (int k = 0; k < dur * TDIV; k++)
        q.push_back('{buz:((half != 0) && (((k / (half == 0 ? 1 : half)) % 2) == 0)),
                      bsy:1'b1, dn:1'b0, ack:1'b0, chk_a:1'b0, fin:1'b0, addr:8'd0});
      for (int k = 0; k < GAPT * TDIV; k++)
        q.push_back('{buz:1'b0, bsy:1'b1, dn:1'b0, ack:1'b0, chk_a:1'b0, fin:1'b0, addr:8'd0});
      notes++;
      if (n.last) break;
      a = (a + 1) % 256;
    end
    e = q.pop_back();
    e.fin = 1'b1;
    q.push_back(e);
    q.push_back('{buz:1'b0, bsy:1'b0, dn:1'b1, ack:1'b0, chk_a:1'b0, fin:1'b0, addr:8'd0});
  endtask

  // One clock cycle: drive req, compare outputs, advance the model
  task automatic cyc(input logic r, input logic [7:0] a, input logic [1:0] p);
    exp_t e;
    req = r; req_addr = a; req_prio = p;
    if (q.size() == 0)
      q.push_back('{buz:1'b0, bsy:1'b0, dn:1'b0, ack:1'b0, chk_a:1'b0, fin:1'b0, addr:8'd0});
    e = q.pop_front();
    chk("buzzer", buzzer_out, e.buz);
    chk("busy", busy, e.bsy);
    chk("done", done, e.dn);
    chk("req_ack", req_ack, e.ack);
    if (e.chk_a) chk("rom_addr", rom_addr, e.addr);
    last_acc = 0;
    if (r && (!e.bsy || ((int'(p) >= model_prio) && !e.fin))) begin
      q.delete();
      push_tune(int'(a));
      model_prio = int'(p);
      last_acc = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 2'd0);
  endtask

  task automatic start(input logic [7:0] a, input logic [1:0] p);
    int n;
    n = 0; last_acc = 0;
    while (!last_acc && n < 40) begin
      cyc(1'b1, a, p);
      n++;
    end
  endtask

  task automatic finish_tune();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20000) begin
      cyc(1'b0, 8'd0, 2'd0);
      n++;
    end
    idle(1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      rom[i] = mk_note($urandom_range(0, 2) == 0, 20'($urandom_range(0, 5)),
                       16'($urandom_range(0, 3)));
    rom[0]   = mk_note(1'b0, 20'd3, 16'd2);
    rom[1]   = mk_note(1'b1, 20'd0, 16'd1);
    rom[20]  = mk_note(1'b0, 20'd2, 16'd3);
    rom[21]  = mk_note(1'b0, 20'd4, 16'd2);
    rom[22]  = mk_note(1'b1, 20'd1, 16'd1);
    rom[40]  = mk_note(1'b0, 20'd5, 16'd3);
    rom[41]  = mk_note(1'b1, 20'd3, 16'd2);
    rom[255] = mk_note(1'b0, 20'd2, 16'd0);

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ack", req_ack, 1'b0);
    chk("rst_buzzer", buzzer_out, 1'b0);
    chk("rst_rom_addr", rom_addr, 8'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic two-note tune with a rest
    start(8'd0, 2'd0);
    finish_tune();

    // Lower priority request is dropped
    start(8'd20, 2'd2);
    idle(5);
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'd40, 2'd1);
    finish_tune();

    // Higher priority preempts mid-note
    start(8'd20, 2'd2);
    idle(8);
    start(8'd40, 2'd3);
    finish_tune();

    // Equal priority restarts at the new address
    start(8'd20, 2'd1);
    idle(6);
    start(8'd0, 2'd1);
    finish_tune();

    // Zero duration and address wrap 255 -> 0
    start(8'd255, 2'd0);
    finish_tune();

    // Request in the completion cycle: completion wins, ack follows
    start(8'd41, 2'd0);
    for (int i = 0; i < 100 && q.size() > 0 && !q[0].fin; i++) cyc(1'b0, 8'd0, 2'd0);
    start(8'd20, 2'd0);
    finish_tune();

    // Request first raised in the done cycle
    start(8'd41, 2'd3);
    for (int i = 0; i < 100 && q.size() > 0 && !q[0].dn; i++) cyc(1'b0, 8'd0, 2'd0);
    start(8'd0, 2'd0);
    finish_tune();

    // Asynchronous reset during PLAY
    start(8'd40, 2'd2);
    idle(6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_buzzer", buzzer_out, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_ack", req_ack, 1'b0);
    q.delete();
    model_prio = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    start(8'd0, 2'd0);
    finish_tune();

    // Randomized tunes with random competing requests
    for (int it = 0; it < 20; it++) begin
      logic [7:0] a, ia;
      logic [1:0] p, ip;
      int wait_n, hold_n;
      a = 8'($urandom_range(0, 255));
      p = 2'($urandom_range(0, 3));
      ia = 8'($urandom_range(0, 255));
      ip = 2'($urandom_range(0, 3));
      wait_n = $urandom_range(0, 15);
      hold_n = $urandom_range(1, 4);
      idle($urandom_range(0, 3));
      start(a, p);
      if ($urandom_range(0, 1) == 1) begin
        idle(wait_n);
        last_acc = 0;
        for (int h = 0; h < hold_n && !last_acc; h++) cyc(1'b1, ia, ip);
      end
      finish_tune();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
